// File: rtl/phase_seq_pkg.sv
// Shared definitions for the phase sequencer.
//   state_t    : one-hot phase encoding; bit order matches {s3, s2, s1, sIDLE}
//   DEF_CNT_W  : default width of the per-phase dwell counts
//   DEF_LOOP_W : default width of the pass count / loop index
package phase_seq_pkg;

  localparam int DEF_CNT_W  = 8;
  localparam int DEF_LOOP_W = 4;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_S1   = 4'b0010,
    ST_S2   = 4'b0100,
    ST_S3   = 4'b1000
  } state_t;

endpackage

// File: rtl/phase_sequencer_dwell_counter.sv
// Loadable down-counter timing how long the sequencer stays in a phase.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (count -> 0)
//   load     : load load_val (takes effect on the next edge)
//   clear    : force count to 0 (priority over load)
//   load_val : dwell length in cycles, must already be >= 1
//   expired  : high during the last cycle of the dwell
module dwell_counter
  import phase_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_reg;

  // A loaded value N means the phase lasts N cycles: the count walks
  // N, N-1, ..., 1 and the cycle showing 1 is the last one. The counter
  // stops at 0, so an idle counter never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CNT_ONE;
    end
  end

  assign expired = (cnt_reg == CNT_ONE);

endmodule

// File: rtl/phase_sequencer.sv
// Four-phase one-hot sequencer IDLE -> S1 -> S2 -> S3 (-> S1 ...) -> IDLE.
// Ports:
//   clk, rst              : clock and synchronous active-high reset
//   start                 : begin a sequence (accepted only in IDLE)
//   abort                 : return to IDLE on the next edge
//   dwell1/dwell2/dwell3  : cycles per phase (0 behaves as 1), latched at start
//   loops                 : number of S1-S2-S3 passes (0 behaves as 1), latched
//   sIDLE/s1/s2/s3        : registered one-hot phase indicators
//   busy                  : high whenever not in IDLE
//   done                  : one-cycle pulse in the first IDLE cycle after a
//                           normally completed sequence
//   loop_cnt              : 0-based index of the current pass
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int CNT_W  = DEF_CNT_W,
  parameter int LOOP_W = DEF_LOOP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  dwell1,
  input  logic [CNT_W-1:0]  dwell2,
  input  logic [CNT_W-1:0]  dwell3,
  input  logic [LOOP_W-1:0] loops,
  output logic              sIDLE,
  output logic              s1,
  output logic              s2,
  output logic              s3,
  output logic              busy,
  output logic              done,
  output logic [LOOP_W-1:0] loop_cnt
);

  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [LOOP_W-1:0] LOOP_ONE = {{(LOOP_W-1){1'b0}}, 1'b1};
  localparam logic [LOOP_W:0]   LOOP_INC = {{LOOP_W{1'b0}}, 1'b1};

  state_t            state_reg, state_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic [LOOP_W-1:0] loop_cnt_reg, loop_cnt_next;

  // Sequence parameters captured at the accepted start, already zero-fixed.
  logic [CNT_W-1:0]  d1_reg, d2_reg, d3_reg;
  logic [LOOP_W-1:0] loops_reg;

  logic [CNT_W-1:0]  d1_fix, d2_fix, d3_fix;
  logic [LOOP_W-1:0] loops_fix;
  logic              accept;
  logic              last_pass;

  logic              cnt_load, cnt_clear, cnt_expired;
  logic [CNT_W-1:0]  cnt_val;

  assign d1_fix    = (dwell1 == '0) ? CNT_ONE : dwell1;
  assign d2_fix    = (dwell2 == '0) ? CNT_ONE : dwell2;
  assign d3_fix    = (dwell3 == '0) ? CNT_ONE : dwell3;
  assign loops_fix = (loops == '0) ? LOOP_ONE : loops;

  // Extra bit so loop_cnt+1 cannot overflow at the widest pass count.
  assign last_pass = (({1'b0, loop_cnt_reg} + LOOP_INC) >= {1'b0, loops_reg});

  dwell_counter #(
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .clear    (cnt_clear),
    .load_val (cnt_val),
    .expired  (cnt_expired)
  );

  always_comb begin
    state_next    = state_reg;
    loop_cnt_next = loop_cnt_reg;
    done_next     = 1'b0;
    cnt_load      = 1'b0;
    cnt_clear     = 1'b0;
    cnt_val       = d1_reg;
    accept        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // abort beats start; the latched copies are not valid yet, so the
        // first dwell comes straight from the inputs.
        if (start && !abort) begin
          accept     = 1'b1;
          state_next = ST_S1;
          cnt_load   = 1'b1;
          cnt_val    = d1_fix;
        end
      end
      ST_S1: begin
        if (abort) begin
          state_next    = ST_IDLE;
          loop_cnt_next = '0;
          cnt_clear     = 1'b1;
        end else if (cnt_expired) begin
          state_next = ST_S2;
          cnt_load   = 1'b1;
          cnt_val    = d2_reg;
        end
      end
      ST_S2: begin
        if (abort) begin
          state_next    = ST_IDLE;
          loop_cnt_next = '0;
          cnt_clear     = 1'b1;
        end else if (cnt_expired) begin
          state_next = ST_S3;
          cnt_load   = 1'b1;
          cnt_val    = d3_reg;
        end
      end
      ST_S3: begin
        if (abort) begin
          state_next    = ST_IDLE;
          loop_cnt_next = '0;
          cnt_clear     = 1'b1;
        end else if (cnt_expired) begin
          if (last_pass) begin
            state_next    = ST_IDLE;
            loop_cnt_next = '0;
            done_next     = 1'b1;
            cnt_clear     = 1'b1;
          end else begin
            state_next    = ST_S1;
            loop_cnt_next = loop_cnt_reg + LOOP_ONE;
            cnt_load      = 1'b1;
            cnt_val       = d1_reg;
          end
        end
      end
      default: begin
        // Any non-one-hot pattern falls back to a clean IDLE.
        state_next    = ST_IDLE;
        loop_cnt_next = '0;
        cnt_clear     = 1'b1;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      loop_cnt_reg <= '0;
      d1_reg       <= '0;
      d2_reg       <= '0;
      d3_reg       <= '0;
      loops_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      loop_cnt_reg <= loop_cnt_next;
      if (accept) begin
        d1_reg    <= d1_fix;
        d2_reg    <= d2_fix;
        d3_reg    <= d3_fix;
        loops_reg <= loops_fix;
      end
    end
  end

  // Phase indicators are the state register bits themselves.
  assign sIDLE    = state_reg[0];
  assign s1       = state_reg[1];
  assign s2       = state_reg[2];
  assign s3       = state_reg[3];
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign loop_cnt = loop_cnt_reg;

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Controller that sequences the four-phase one-hot state flow IDLE -> S1 -> S2 -> S3 on command.
- Each active phase is held for a programmable dwell time. The S1..S3 pass repeats a programmable number of times.
- Start/busy/done handshake to the upstream master; abort returns to IDLE immediately.
- Outputs sIDLE/s1/s2/s3 drive downstream phase-gated logic directly.

Parameters:
- CNT_W, 8, width of the per-phase dwell counts.
- LOOP_W, 4, width of the pass count and the loop_cnt output.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a sequence; sampled only in IDLE.
- abort  in  1  terminate the sequence; return to IDLE.
- dwell1  in  CNT_W  cycles spent in S1.
- dwell2  in  CNT_W  cycles spent in S2.
- dwell3  in  CNT_W  cycles spent in S3.
- loops  in  LOOP_W  number of S1-S2-S3 passes.
- sIDLE  out  1  phase indicator, IDLE.
- s1  out  1  phase indicator, S1.
- s2  out  1  phase indicator, S2.
- s3  out  1  phase indicator, S3.
- busy  out  1  high whenever not in IDLE.
- done  out  1  one-cycle pulse on normal completion.
- loop_cnt  out  LOOP_W  index of the current pass, 0-based.

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset values:
  - sIDLE=1; s1=s2=s3=0.
  - busy=0, done=0, loop_cnt=0.
  - Internal dwell and pass counters = 0.
- All outputs are registered. Exactly one of sIDLE/s1/s2/s3 is high in every cycle, including the cycle after reset.
- Start latency: start=1 sampled in IDLE at edge N gives s1=1 and busy=1 from edge N+1.
- Dwell1..3 and loops are latched at the accepted start. Changes while busy are ignored.
- Zero handling: a dwell value of 0 is treated as 1. loops=0 is treated as 1.
- Dwell rule: the phase output stays high for exactly max(dwellX,1) cycles, then the next phase is entered.
- Transitions:
  - S1 -> S2 -> S3.
  - S3 -> S1 if passes remain; loop_cnt increments on that edge.
  - S3 -> IDLE after the final pass.
- Completion:
  - done=1 for exactly one cycle, the first IDLE cycle after the last S3.
  - busy=0 in that same cycle.
  - loop_cnt clears to 0 on entry to IDLE.
- start while busy: ignored, no queuing.
- start in the done cycle: accepted, since the block is already in IDLE. s1 rises on the next edge and done is still a clean 1-cycle pulse.
- abort:
  - In any non-IDLE phase, the next edge forces IDLE with busy=0, done=0, loop_cnt=0.
  - Abort beats dwell expiry in the same cycle.
  - In IDLE, abort has no effect. If start and abort are both high in IDLE, abort wins and the block stays IDLE.
- rst mid-sequence: same result as abort, plus done=0. rst has priority over abort and start.
- Counter width: the dwell counter is CNT_W bits. max dwell = 2^CNT_W-1 cycles, with no wrap during a phase.
- An illegal or non-one-hot state register recovers to IDLE on the next edge.

Decomposition:
- Shared package phase_seq_pkg holds:
  - State encoding constants ST_IDLE=4'b0001, ST_S1=4'b0010, ST_S2=4'b0100, ST_S3=4'b1000.
  - Default CNT_W and LOOP_W.
- The outputs sIDLE/s1/s2/s3 are the state register bits directly.
- One sub-module, dwell_counter:
  - Loadable CNT_W down-counter with load, clear and expire flag.
  - Instantiated once and reloaded on every phase entry.
- The pass counter stays inline.

Test Plan:
- Reset:
  - Stimulus: rst high for 10 cycles, then low.
  - Required: sIDLE=1, s1=s2=s3=0, busy=0, done=0, loop_cnt=0 throughout and after.
- Single pass:
  - Stimulus: dwell1=3, dwell2=2, dwell3=4, loops=1, start pulse at cycle 20.
  - Required:
    - s1 high cycles 21-23, s2 high 24-25, s3 high 26-29.
    - done=1 at cycle 30 only; busy high 21-29.
- Multi-pass and zero handling:
  - Stimulus: dwell1=dwell2=dwell3=0, loops=3.
  - Required:
    - Each phase lasts 1 cycle and the S1-S2-S3 pattern repeats 3 times.
    - loop_cnt reads 0, 1, 2, then 0 in IDLE.
    - done is pulsed once, 10 cycles after the start edge.
- Abort:
  - Stimulus: dwell2=5; assert abort in the 2nd cycle of S2.
  - Required: next cycle sIDLE=1, busy=0, done never pulses, loop_cnt=0.
  - Also: start and abort together in IDLE leave the block IDLE.
- Start while busy, and back-to-back start:
  - Stimulus: start pulses during S2; later, start asserted in the done cycle.
  - Required: the mid-run start is ignored and the timing is unchanged. The start in the done cycle produces s1 on the next cycle.
- Mid-run input change and reset:
  - Stimulus: change dwell3 from 4 to 9 during S1.
  - Required: S3 still lasts 4 cycles.
  - Stimulus: assert rst during S3.
  - Required: IDLE on the next cycle with all reset values.
